// File: rtl/font_rom_arbiter_if.sv
// Request/response bundle between the font ROM arbiter,
// its two requesters and the font_rom read port.
interface font_rom_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              valid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              valid1;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              starve1;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, valid0, gnt1, valid1, rd_data, rom_addr, starve1
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, valid0, gnt1, valid1, rd_data, rom_addr, starve1
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// Fixed-priority arbiter for the shared font_rom read port:
// port 0 (text painter) always wins, port 1 uses idle cycles.
module font_rom_arbiter #(
    parameter int ROM_LAT    = 1,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = 64
) (
    input  logic           clk,
    input  logic           reset,
    font_rom_arbiter_if.slave bus
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    logic                    gnt0;
    logic                    gnt1;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W-1:0]       addr_d;
    logic [ROM_LAT-1:0][1:0] tag_q;
    logic [ROM_LAT-1:0][1:0] tag_d;
    logic [7:0]              wait1_q;
    logic [7:0]              wait1_d;
    logic                    starve_q;

    // Grants are combinational so an access issues in the request cycle.
    assign gnt0 = reset & bus.req0;
    assign gnt1 = reset & bus.req1 & ~bus.req0;

    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;

    // Address mux; with no request the last address is held to avoid toggling.
    always_comb begin
        addr_d = addr_q;
        if (bus.req0) begin
            addr_d = bus.addr0;
        end else if (bus.req1) begin
            addr_d = bus.addr1;
        end
    end

    assign bus.rom_addr = reset ? addr_d : '0;

    // Hold register for the last driven ROM address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Next tag pipeline: new owner tag enters stage 0, others shift up.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = {gnt0, gnt1};
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag pipeline matching the ROM latency; reset drops in-flight reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign bus.valid0  = tag_q[ROM_LAT-1][1];
    assign bus.valid1  = tag_q[ROM_LAT-1][0];
    assign bus.rd_data = bus.rom_data;

    // Consecutive denied port-1 cycles, saturating at 255.
    always_comb begin
        wait1_d = wait1_q;
        if (!bus.req1 || gnt1) begin
            wait1_d = '0;
        end else if (wait1_q != 8'hFF) begin
            wait1_d = wait1_q + 8'd1;
        end
    end

    // Wait counter and registered starvation flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait1_q  <= '0;
            starve_q <= 1'b0;
        end else begin
            wait1_q  <= wait1_d;
            starve_q <= (wait1_d >= LIM);
        end
    end

    assign bus.starve1 = starve_q;

endmodule
